// File: rtl/half_adder_bist.sv
`default_nettype none
// ============================================================================
// Module      : half_adder_bist
// Description : Built-in self-test controller for a WIDTH-bit adder. It walks
//               every operand pair {a,b}, compares the adder's {carry,sum}
//               against a golden sum, and reports the mismatch count and the
//               first failing vector.
//               Optional build macro HALF_ADDER_BIST_LFSR_EN replaces the
//               exhaustive binary counter with a maximal-length 2*WIDTH-bit
//               Fibonacci LFSR seeded with 1 (the all-zero vector is skipped).
// Revision    : 1.0 - initial release
// ============================================================================
module half_adder_bist #(
  parameter int WIDTH    = 4,  // operand width, 1..8
  parameter int RESP_LAT = 1   // drive-to-sample latency, 1..7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  input  logic [WIDTH-1:0]     dut_sum,
  input  logic                 dut_carry,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           err_count,
  output logic [2*WIDTH-1:0]   first_fail
);

  localparam int c_iw = 2 * WIDTH;

  // Last value of the WAIT counter before moving on to CHECK; only used
  // when RESP_LAT > 1, so the clamp keeps the constant non-negative.
  localparam logic [2:0] c_wait_last = 3'((RESP_LAT > 1) ? (RESP_LAT - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [c_iw-1:0]   r_idx;       // sequence generator state
  logic [c_iw-1:0]   r_vec;       // vector currently presented to the adder
  logic [c_iw-1:0]   w_idx_next;
  logic [c_iw-1:0]   w_seed;
  logic              w_last;      // r_idx is the final vector of the run
  logic [2:0]        r_wait;
  logic [7:0]        r_err;
  logic [c_iw-1:0]   r_first;
  logic              w_accept;
  logic [WIDTH:0]    w_golden;
  logic              w_mismatch;

`ifdef HALF_ADDER_BIST_LFSR_EN
  // Feedback tap masks for maximal-length Fibonacci LFSRs of the even
  // lengths a 2*WIDTH index can take (bit n-1 set for tap n).
  function automatic logic [15:0] lfsr_taps(input int n);
    case (n)
      2:       lfsr_taps = 16'h0003;
      4:       lfsr_taps = 16'h000C;
      6:       lfsr_taps = 16'h0030;
      8:       lfsr_taps = 16'h00B8;
      10:      lfsr_taps = 16'h0240;
      12:      lfsr_taps = 16'h0829;
      14:      lfsr_taps = 16'h2015;
      16:      lfsr_taps = 16'hD008;
      default: lfsr_taps = 16'h0003;
    endcase
  endfunction

  localparam logic [15:0] c_taps_full = lfsr_taps(c_iw);

  logic w_fb;

  // LFSR step; the run ends when the sequence would return to the seed.
  always_comb begin
    w_seed     = {{(c_iw-1){1'b0}}, 1'b1};
    w_fb       = ^(r_idx & c_taps_full[c_iw-1:0]);
    w_idx_next = {r_idx[c_iw-2:0], w_fb};
    w_last     = (w_idx_next == w_seed);
  end
`else
  // Binary up-counter; the all-ones vector is the last, then wrap to 0.
  always_comb begin
    w_seed     = '0;
    w_idx_next = r_idx + {{(c_iw-1){1'b0}}, 1'b1};
    w_last     = &r_idx;
  end
`endif

  // Golden response and comparison against what the adder returned.
  always_comb begin
    w_golden   = {1'b0, r_vec[c_iw-1:WIDTH]} + {1'b0, r_vec[WIDTH-1:0]};
    w_mismatch = ({dut_carry, dut_sum} != w_golden);
    w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_DRIVE;
      S_DRIVE: w_state_next = (RESP_LAT > 1) ? S_WAIT : S_CHECK;
      S_WAIT:  if (r_wait == c_wait_last) w_state_next = S_CHECK;
      S_CHECK: w_state_next = w_last ? S_DONE : S_DRIVE;
      S_DONE:  if (start) w_state_next = S_DRIVE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Vector sequencing, latency counting and result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_vec   <= '0;
      r_wait  <= '0;
      r_err   <= '0;
      r_first <= '0;
    end else if (w_accept) begin
      r_idx   <= w_seed;
      r_vec   <= w_seed;
      r_wait  <= '0;
      r_err   <= '0;
      r_first <= '0;
    end else begin
      case (r_state)
        S_DRIVE: r_wait <= '0;
        S_WAIT:  r_wait <= r_wait + 3'd1;
        S_CHECK: begin
          if (w_mismatch) begin
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
            if (r_err == 8'h00) r_first <= r_vec;
          end
          r_idx <= w_idx_next;
          // The presented vector holds after the final check.
          if (!w_last) r_vec <= w_idx_next;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and the accumulated result.
  always_comb begin
    dut_a      = r_vec[c_iw-1:WIDTH];
    dut_b      = r_vec[WIDTH-1:0];
    busy       = (r_state == S_DRIVE) || (r_state == S_WAIT) || (r_state == S_CHECK);
    done       = (r_state == S_DONE);
    pass       = done && (r_err == 8'h00);
    err_count  = r_err;
    first_fail = r_first;
  end

endmodule
`default_nettype wire
